// File: rtl/estoque_multi_lote.sv
// Cork stock/line manager: moves batches of up to BATCH corks from stock to line when the line runs low.
// Latency: dispenser_on rises one edge after the line is seen low; one cork per acknowledged cycle after that.
// Backpressure: disp_ack low stalls the batch indefinitely. Define ESTOQUE_HYST_EN for low-alarm hysteresis.
module estoque_multi_lote #(
    parameter int W           = 8,
    parameter int STOCK_INIT  = 40,
    parameter int STOCK_MAX   = 99,
    parameter int REFILL_STEP = 5,
    parameter int LINE_LOW    = 5,
    parameter int BATCH       = 15,
    parameter int LOW_SET     = 15,
    parameter int LOW_CLR     = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         done,
    input  logic         add_rolha,
    input  logic         disp_ack,
    output logic [W-1:0] stock_count,
    output logic [W-1:0] line_count,
    output logic         dispenser_on,
    output logic [W-1:0] batch_left,
    output logic         low_alarm,
    output logic         empty_alarm,
    output logic         refill_reject
);

    typedef enum logic [1:0] {IDLE, DISPENSE, EMPTY} state_t;

    localparam logic [W-1:0] ZERO_W     = '0;
    localparam logic [W-1:0] ONE_W      = W'(1);
    localparam logic [W-1:0] INIT_W     = W'(STOCK_INIT);
    localparam logic [W-1:0] MAX_W      = W'(STOCK_MAX);
    localparam logic [W:0]   MAX_X      = (W+1)'(STOCK_MAX);
    localparam logic [W:0]   STEP_X     = (W+1)'(REFILL_STEP);
    localparam logic [W-1:0] LINE_LOW_W = W'(LINE_LOW);
    localparam logic [W-1:0] BATCH_W    = W'(BATCH);
    localparam logic [W:0]   LINE_SAT_X = {1'b0, {W{1'b1}}};
    // Set threshold clamped to LOW_CLR so a misordered pair can never invert the hysteresis band.
    localparam logic [W-1:0] LOW_SET_W  = W'((LOW_SET < LOW_CLR) ? LOW_SET : LOW_CLR);
`ifdef ESTOQUE_HYST_EN
    localparam logic [W-1:0] LOW_CLR_W  = W'(LOW_CLR);
`endif

    state_t       state;
    logic         xfer;
    logic         at_max;
    logic         consume;
    logic         line_low;
    logic [W:0]   stock_dec;
    logic [W:0]   stock_sum;
    logic [W:0]   line_sum;
    logic [W-1:0] stock_next;
    logic [W-1:0] line_next;
    logic [W-1:0] batch_load;

    assign xfer        = (state == DISPENSE) && disp_ack && (batch_left != ZERO_W) && (stock_count != ZERO_W);
    assign at_max      = (stock_count == MAX_W);
    assign consume     = done && (line_count != ZERO_W);
    assign line_low    = (line_count <= LINE_LOW_W);
    assign batch_load  = (stock_count < BATCH_W) ? stock_count : BATCH_W;
    assign empty_alarm = (stock_count == ZERO_W);

    always_comb begin
        stock_dec  = {1'b0, stock_count} - {{W{1'b0}}, xfer};
        stock_sum  = stock_dec + STEP_X;
        stock_next = stock_dec[W-1:0];
        if (add_rolha && !at_max) begin
            stock_next = (stock_sum > MAX_X) ? MAX_W : stock_sum[W-1:0];
        end
        line_sum  = {1'b0, line_count} + {{W{1'b0}}, xfer} - {{W{1'b0}}, consume};
        line_next = (line_sum > LINE_SAT_X) ? LINE_SAT_X[W-1:0] : line_sum[W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            stock_count   <= INIT_W;
            line_count    <= ZERO_W;
            batch_left    <= ZERO_W;
            dispenser_on  <= 1'b0;
            low_alarm     <= 1'b0;
            refill_reject <= 1'b0;
        end else begin
            stock_count   <= stock_next;
            line_count    <= line_next;
            refill_reject <= add_rolha && at_max;
`ifdef ESTOQUE_HYST_EN
            if (stock_count < LOW_SET_W) begin
                low_alarm <= 1'b1;
            end else if (stock_count >= LOW_CLR_W) begin
                low_alarm <= 1'b0;
            end
`else
            low_alarm <= (stock_count < LOW_SET_W);
`endif
            case (state)
                IDLE: begin
                    if (line_low) begin
                        if (stock_count != ZERO_W) begin
                            state        <= DISPENSE;
                            dispenser_on <= 1'b1;
                            batch_left   <= batch_load;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                DISPENSE: begin
                    if (xfer) begin
                        batch_left <= batch_left - ONE_W;
                        if (batch_left == ONE_W) begin
                            state        <= IDLE;
                            dispenser_on <= 1'b0;
                        end
                    end else if (batch_left == ZERO_W) begin
                        state        <= IDLE;
                        dispenser_on <= 1'b0;
                    end
                end
                EMPTY: begin
                    if (stock_count != ZERO_W) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    dispenser_on <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/estoque_multi_lote.md
Name: estoque_multi_lote

Overview:
- Parametrised successor to the cork-stock manager.
- Holds a stock counter and a line counter. When the line runs low, it moves a batch from stock to line through a dispenser handshake, one cork per acknowledged cycle, instead of one bulk jump.
- Adds saturating refill, refill rejection, empty/low alarms and an optional low-alarm hysteresis.
- Sits between the capping FSM (`done` pulses) and the operator refill button (`add_rolha`).

Parameters:
- W, 8, width of all counters.
- STOCK_INIT, 40, stock value loaded at reset.
- STOCK_MAX, 99, stock capacity; refills saturate here.
- REFILL_STEP, 5, corks added per `add_rolha` pulse.
- LINE_LOW, 5, line level at or below which a batch is requested.
- BATCH, 15, nominal batch size.
- LOW_SET, 15, low alarm asserts when stock < LOW_SET.
- LOW_CLR, 20, low alarm clears when stock >= LOW_CLR (hysteresis build only); must be >= LOW_SET.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- done  in  1  one-cycle pulse: one cork consumed from the line.
- add_rolha  in  1  one-cycle pulse: operator adds REFILL_STEP corks to stock.
- disp_ack  in  1  dispenser accepted one cork this cycle.
- stock_count  out  W  corks in stock.
- line_count  out  W  corks on the line.
- dispenser_on  out  1  dispenser request; high in state DISPENSE.
- batch_left  out  W  corks still to transfer in the current batch.
- low_alarm  out  1  stock-low alarm, registered.
- empty_alarm  out  1  stock_count == 0; combinational from the register.
- refill_reject  out  1  one-cycle pulse: `add_rolha` arrived with stock == STOCK_MAX.

Behaviour:
- Reset (`reset` low, asynchronous) sets:
  - stock_count = STOCK_INIT, line_count = 0, batch_left = 0
  - state = IDLE, dispenser_on = 0, low_alarm = 0, refill_reject = 0
- Reset mid-batch aborts the batch; corks already transferred stay counted as at reset (i.e. discarded).
- FSM states are IDLE, DISPENSE and EMPTY.
- IDLE:
  - If line_count <= LINE_LOW and stock_count > 0: go to DISPENSE next edge, with batch_left = min(stock_count, BATCH).
  - If line_count <= LINE_LOW and stock_count == 0: go to EMPTY.
- DISPENSE:
  - dispenser_on = 1.
  - Each cycle with disp_ack = 1: stock_count -1, line_count +1, batch_left -1.
  - The cycle that moves batch_left from 1 to 0 returns to IDLE.
  - disp_ack = 0 stalls the transfer with no timeout.
- EMPTY:
  - Waits until stock_count > 0, then returns to IDLE.
- Latency: from reset release with line 0, dispenser_on rises after 1 edge. A full batch with ack held high takes BATCH cycles.
- `done`:
  - Decrements line_count if line_count > 0; ignored at 0.
  - Accepted in every state.
  - `done` in the same cycle as an acknowledged transfer leaves line_count unchanged (+1 and -1 net out).
- `add_rolha`:
  - stock_count = min(stock_count + REFILL_STEP, STOCK_MAX), accepted in every state.
  - Same cycle as an acknowledged transfer: stock_count = min(stock_count - 1 + REFILL_STEP, STOCK_MAX).
  - If stock_count == STOCK_MAX (before any transfer that cycle), refill_reject pulses for 1 cycle and no corks are added.
- A refill during DISPENSE does not resize the current batch.
- All arithmetic is W bits, computed internally in W+1 bits. No wrap is permitted; saturate at STOCK_MAX and at 0.
- low_alarm is updated each edge from the current stock_count, so it lags stock_count by 1 cycle.
- empty_alarm = (stock_count == 0).

Optional Feature:
- Macro: ESTOQUE_HYST_EN.
- Defined:
  - low_alarm sets when stock_count < LOW_SET.
  - It clears only when stock_count >= LOW_CLR.
  - Between the two thresholds it holds its previous value.
- Undefined:
  - low_alarm = (stock_count < LOW_SET), registered; LOW_CLR is unused.

Test Plan:
- Reset release, disp_ack = 1 constant, no done → dispenser_on = 1 after 1 edge; after 15 transfers stock = 25, line = 15, batch_left = 0, state IDLE, dispenser_on = 0.
- Stock forced to 7 via reset variant (STOCK_INIT = 7), line 0 → batch_left loads 7; after 7 acks stock = 0, line = 7, empty_alarm = 1; then 2 `done` pulses bring line to 5 → state EMPTY, dispenser_on stays 0.
- Stall mid-batch: disp_ack low for 10 cycles at batch_left = 8 → counters frozen, dispenser_on held 1; resumes on ack.
- Refill saturation: stock 97, `add_rolha` → 99; second `add_rolha` → stays 99, refill_reject pulses 1 cycle.
- Simultaneous `done` + acked transfer + `add_rolha` at stock 30, line 3 → line 3, stock 34.
- Hysteresis (ESTOQUE_HYST_EN):
  - Stock drops 16→14 → low_alarm = 1 on the following edge.
  - Refill to 19 → alarm stays 1.
  - Refill to 24 → alarm clears.
  - Without the macro, same stimulus → alarm clears at 19.
- Assert `reset` mid-batch → all outputs at reset values immediately, without a clock edge.
